// File: rtl/nibble_loader_pkg.sv
// Shared definitions for the nibble loader bank: command encoding and the
// parameter derivations used by both the bank and its channels.
package nibble_loader_pkg;

  // Host command encoding on the 2-bit cmd pins.
  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_SHIFT  = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_COMMIT = 2'b11
  } cmd_e;

  // Number of DIN_W-bit nibbles that fill one REG_W-bit register.
  function automatic int calc_nibs(input int reg_w, input int din_w);
    return reg_w / din_w;
  endfunction

  // Counter width able to hold 0..NIBS inclusive.
  function automatic int calc_cnt_w(input int reg_w, input int din_w);
    return $clog2(calc_nibs(reg_w, din_w) + 1);
  endfunction

  // Channel select width; at least one bit even for a single channel.
  function automatic int calc_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/nibble_loader_channel.sv
// One loader channel: shift register filled a nibble at a time, fill
// counter saturating at NIBS, sticky overflow, committed shadow register
// and a one-cycle commit pulse. The bank decodes the shared command bus
// into cmd_i, so an unselected channel simply sees CMD_NOP.
module nibble_loader_channel
  import nibble_loader_pkg::*;
#(
  parameter int REG_W = 128,
  parameter int DIN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  cmd_e             cmd_i,
  input  logic [DIN_W-1:0] din_i,
  output logic [REG_W-1:0] shadow_o,
  output logic [DIN_W-1:0] sr_top_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             commit_pulse_o
);

  localparam int NIBS  = calc_nibs(REG_W, DIN_W);
  localparam int CNT_W = calc_cnt_w(REG_W, DIN_W);

  logic [REG_W-1:0] sr_q, sr_d;
  logic [REG_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             full;

  // Full is decoded straight from the registered count.
  assign full = (cnt_q == CNT_W'(NIBS));

  // Next-state decode for the selected command.
  always_comb begin
    // NOTE: every next-state variable gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sr_d     = sr_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    pulse_d  = 1'b0;
    case (cmd_i)
      CMD_SHIFT: begin
        if (!full) begin
          // Shift left and drop the new nibble into the LSBs; the first
          // nibble loaded reaches the MSBs after NIBS shifts.
          sr_d  = (sr_q << DIN_W) | REG_W'(din_i);
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      CMD_CLEAR: begin
        sr_d  = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      CMD_COMMIT: begin
        // An early commit is ignored here; the bank flags it as an error.
        if (full) begin
          shadow_d = sr_q;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          pulse_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow is a wide register rather than a memory, and it is
      // reset because downstream logic must see zero operands after reset.
      sr_q     <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      pulse_q  <= pulse_d;
    end
  end

  assign shadow_o       = shadow_q;
  assign sr_top_o       = sr_q[REG_W-1 -: DIN_W];
  assign full_o         = full;
  assign overflow_o     = ovf_q;
  assign commit_pulse_o = pulse_q;

endmodule

// File: rtl/nibble_loader_bank.sv
// Bank of NUM_CH nibble loader channels sharing one command bus. The top
// level validates and decodes the channel select, flags rejected commands
// on err, and registers the top nibble of the selected shift register.
// REG_W must be a multiple of DIN_W.
module nibble_loader_bank
  import nibble_loader_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int REG_W  = 128,
  parameter int DIN_W  = 4,
  parameter int SEL_W  = calc_sel_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_W-1:0]        din,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              cmd,
  output logic [NUM_CH*REG_W-1:0] shadow_out,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       commit_pulse,
  output logic                    err,
  output logic [DIN_W-1:0]        rd_data
);

  cmd_e             cmd_dec;
  logic             sel_valid;
  logic [NUM_CH-1:0] ch_hit;
  logic [DIN_W-1:0] sr_top [NUM_CH];

  logic             sel_full;
  logic [DIN_W-1:0] sel_top;
  logic             err_q, err_d;
  logic [DIN_W-1:0] rd_q, rd_d;

  assign cmd_dec   = cmd_e'(cmd);
  assign sel_valid = (int'(sel) < NUM_CH);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cmd_e ch_cmd;

    // Only the addressed channel sees the command; the rest see NOP.
    assign ch_hit[k] = sel_valid && (int'(sel) == k);
    assign ch_cmd    = ch_hit[k] ? cmd_dec : CMD_NOP;

    nibble_loader_channel #(
      .REG_W (REG_W),
      .DIN_W (DIN_W)
    ) u_channel (
      .clk            (clk),
      .rst            (rst),
      .cmd_i          (ch_cmd),
      .din_i          (din),
      .shadow_o       (shadow_out[k*REG_W +: REG_W]),
      .sr_top_o       (sr_top[k]),
      .full_o         (full[k]),
      .overflow_o     (overflow[k]),
      .commit_pulse_o (commit_pulse[k])
    );
  end

  // Select mux for the addressed channel's status and top nibble; an
  // invalid select leaves both at zero.
  always_comb begin
    sel_full = 1'b0;
    sel_top  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_hit[k]) begin
        sel_full = full[k];
        sel_top  = sr_top[k];
      end
    end
  end

  // Reject any non-NOP command to a missing channel, and any commit to a
  // channel that is not yet full.
  always_comb begin
    err_d = 1'b0;
    if (cmd_dec != CMD_NOP) begin
      if (!sel_valid) begin
        err_d = 1'b1;
      end else if (cmd_dec == CMD_COMMIT && !sel_full) begin
        err_d = 1'b1;
      end
    end
    rd_d = sel_top;
  end

  // Error pulse and readback registers, sampled every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      err_q <= err_d;
      rd_q  <= rd_d;
    end
  end

  assign err     = err_q;
  assign rd_data = rd_q;

endmodule

// File: tb/tb_nibble_loader_bank.sv
// Directed plus short random test of nibble_loader_bank with NUM_CH=3,
// REG_W=32, DIN_W=4. Each step drives one command, pushes the expected
// post-edge outputs from a reference model onto a scoreboard, and pops
// and compares them one time unit after the clock edge.
module tb_nibble_loader_bank;
  import nibble_loader_pkg::*;

  localparam int NUM_CH = 3;
  localparam int REG_W  = 32;
  localparam int DIN_W  = 4;
  localparam int NIBS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din;
  logic [1:0]  sel;
  logic [1:0]  cmd;
  logic [95:0] shadow_out;
  logic [2:0]  full;
  logic [2:0]  overflow;
  logic [2:0]  commit_pulse;
  logic        err;
  logic [3:0]  rd_data;

  nibble_loader_bank #(
    .NUM_CH (NUM_CH),
    .REG_W  (REG_W),
    .DIN_W  (DIN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .sel          (sel),
    .cmd          (cmd),
    .shadow_out   (shadow_out),
    .full         (full),
    .overflow     (overflow),
    .commit_pulse (commit_pulse),
    .err          (err),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] shadow;
    logic [2:0]  full;
    logic [2:0]  ovf;
    logic [2:0]  pulse;
    logic        err;
    logic [3:0]  rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_sr  [NUM_CH];
  logic [31:0] m_sh  [NUM_CH];
  int          m_cnt [NUM_CH];
  logic        m_ovf [NUM_CH];

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int stepno = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: apply one command and return the outputs expected
  // just after the clock edge that samples it.
  task automatic model_apply(input logic r, input logic [1:0] c, input logic [1:0] s,
                             input logic [3:0] d, output exp_t e);
    bit valid;
    e.pulse = 3'b000;
    e.err   = 1'b0;
    e.rd    = 4'h0;
    if (r) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_sr[k] = '0; m_sh[k] = '0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
      end
    end else begin
      valid = (s < NUM_CH);
      if (valid) e.rd = m_sr[s][31:28];
      if (c != CMD_NOP) begin
        if (!valid) begin
          e.err = 1'b1;
        end else begin
          case (c)
            CMD_SHIFT: begin
              if (m_cnt[s] < NIBS) begin
                m_sr[s]  = {m_sr[s][27:0], d};
                m_cnt[s] = m_cnt[s] + 1;
              end else begin
                m_ovf[s] = 1'b1;
              end
            end
            CMD_CLEAR: begin
              m_sr[s] = '0; m_cnt[s] = 0; m_ovf[s] = 1'b0;
            end
            default: begin
              if (m_cnt[s] == NIBS) begin
                m_sh[s]    = m_sr[s];
                m_cnt[s]   = 0;
                m_ovf[s]   = 1'b0;
                e.pulse[s] = 1'b1;
              end else begin
                e.err = 1'b1;
              end
            end
          endcase
        end
      end
    end
    e.shadow = {m_sh[2], m_sh[1], m_sh[0]};
    for (int k = 0; k < NUM_CH; k++) begin
      e.full[k] = (m_cnt[k] == NIBS);
      e.ovf[k]  = m_ovf[k];
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1 at step %0d", stepno);
    end else begin
      e = sb.pop_front();
      check($sformatf("shadow_out@%0d", stepno), shadow_out, e.shadow);
      check($sformatf("full@%0d", stepno), 96'(full), 96'(e.full));
      check($sformatf("overflow@%0d", stepno), 96'(overflow), 96'(e.ovf));
      check($sformatf("commit_pulse@%0d", stepno), 96'(commit_pulse), 96'(e.pulse));
      check($sformatf("err@%0d", stepno), 96'(err), 96'(e.err));
      check($sformatf("rd_data@%0d", stepno), 96'(rd_data), 96'(e.rd));
    end
  endtask

  task automatic step(input logic r, input logic [1:0] c, input logic [1:0] s, input logic [3:0] d);
    exp_t e;
    rst = r; cmd = c; sel = s; din = d;
    model_apply(r, c, s, d, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    compare_outputs();
  endtask

  task automatic load8(input logic [1:0] s, input logic [31:0] word);
    for (int i = 7; i >= 0; i--) step(1'b0, CMD_SHIFT, s, word[i*4 +: 4]);
  endtask

  initial begin
    int r;
    rst = 1'b1; cmd = CMD_NOP; sel = 2'd0; din = 4'h0;

    // Reset state.
    step(1'b1, CMD_NOP, 2'd0, 4'h0);
    step(1'b1, CMD_NOP, 2'd0, 4'h0);
    check("reset_shadow", shadow_out, 96'h0);
    check("reset_rd", 96'(rd_data), 96'h0);
    step(1'b0, CMD_NOP, 2'd0, 4'h0);

    // Load and commit ch0 with 1..8.
    load8(2'd0, 32'h12345678);
    check("load_full0", 96'(full[0]), 96'h1);
    step(1'b0, CMD_COMMIT, 2'd0, 4'h0);
    check("load_shadow0", 96'(shadow_out[31:0]), 96'h12345678);
    check("load_pulse", 96'(commit_pulse), 96'h1);
    check("load_other_shadows", 96'(shadow_out[95:32]), 96'h0);
    step(1'b0, CMD_NOP, 2'd0, 4'h0);
    check("load_pulse_gone", 96'(commit_pulse), 96'h0);
    check("load_full0_gone", 96'(full[0]), 96'h0);

    // Overflow on ch1.
    load8(2'd1, 32'hAAAAAAAA);
    step(1'b0, CMD_SHIFT, 2'd1, 4'hF);
    check("ovf_set", 96'(overflow[1]), 96'h1);
    step(1'b0, CMD_NOP, 2'd1, 4'h0);
    check("ovf_sticky", 96'(overflow[1]), 96'h1);
    check("ovf_rd_top", 96'(rd_data), 96'hA);
    step(1'b0, CMD_CLEAR, 2'd1, 4'h0);
    check("ovf_clear", 96'(overflow[1]), 96'h0);
    check("ovf_clear_full", 96'(full[1]), 96'h0);

    // Early commit on ch2, then completion.
    for (int i = 0; i < 5; i++) step(1'b0, CMD_SHIFT, 2'd2, 4'(i + 3));
    step(1'b0, CMD_COMMIT, 2'd2, 4'h0);
    check("early_err", 96'(err), 96'h1);
    check("early_shadow2", 96'(shadow_out[95:64]), 96'h0);
    step(1'b0, CMD_NOP, 2'd2, 4'h0);
    check("early_err_gone", 96'(err), 96'h0);
    for (int i = 0; i < 3; i++) step(1'b0, CMD_SHIFT, 2'd2, 4'(i + 8));
    step(1'b0, CMD_COMMIT, 2'd2, 4'h0);
    check("late_shadow2", 96'(shadow_out[95:64]), 96'h3456789A);

    // Readback of ch1, then back-to-back commits on ch0 and ch1.
    load8(2'd1, 32'h9ABCDEF0);
    step(1'b0, CMD_NOP, 2'd1, 4'h0);
    check("readback", 96'(rd_data), 96'h9);
    load8(2'd0, 32'hC0FFEE11);
    step(1'b0, CMD_COMMIT, 2'd0, 4'h0);
    check("b2b_pulse0", 96'(commit_pulse), 96'h1);
    step(1'b0, CMD_COMMIT, 2'd1, 4'h0);
    check("b2b_pulse1", 96'(commit_pulse), 96'h2);
    check("b2b_shadow1", 96'(shadow_out[63:32]), 96'h9ABCDEF0);

    // Invalid select.
    step(1'b0, CMD_SHIFT, 2'd3, 4'h7);
    check("badsel_err", 96'(err), 96'h1);
    check("badsel_rd", 96'(rd_data), 96'h0);
    step(1'b0, CMD_COMMIT, 2'd3, 4'h0);
    step(1'b0, CMD_CLEAR, 2'd3, 4'h0);
    step(1'b0, CMD_NOP, 2'd3, 4'h0);
    check("badsel_nop_err", 96'(err), 96'h0);

    // Reset mid-load with a commit in the same cycle.
    for (int i = 0; i < 4; i++) step(1'b0, CMD_SHIFT, 2'd0, 4'hD);
    step(1'b1, CMD_COMMIT, 2'd0, 4'h0);
    check("rst_shadow", shadow_out, 96'h0);
    check("rst_pulse", 96'(commit_pulse), 96'h0);
    check("rst_full", 96'(full), 96'h0);
    load8(2'd0, 32'h87654321);
    step(1'b0, CMD_COMMIT, 2'd0, 4'h0);
    check("rst_reload", 96'(shadow_out[31:0]), 96'h87654321);

    // Short random phase biased toward shifts.
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      step(1'b0, (r < 6) ? CMD_SHIFT : (r == 6) ? CMD_CLEAR : (r < 9) ? CMD_COMMIT : CMD_NOP,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nibble_loader_bank.md
# nibble_loader_bank

Parametrised nibble-serial register loader: NUM_CH independent channels, each a REG_W-bit shift register filled DIN_W bits per clock from the shared `ui_in` pins. Each channel has a shadow (committed) register, so downstream compute logic sees only complete, stable operands. It generalises the fixed two-channel weights/data loaders to N channels and adds:
- per-channel fill counting and full/overflow status
- explicit commit and clear commands
- registered readback of the selected channel

## Interface
- NUM_CH, default 2: number of channels (≥1).
- REG_W, default 128: bits per channel. Must be a multiple of DIN_W.
- DIN_W, default 4: bits shifted in per SHIFT command.
- SEL_W, default $clog2(NUM_CH) (min 1): width of the channel select.
- clk  in  1: sole clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- din  in  DIN_W: serial data nibble.
- sel  in  SEL_W: target channel.
- cmd  in  2: 00 NOP, 01 SHIFT, 10 CLEAR, 11 COMMIT.
- shadow_out  out  NUM_CH*REG_W: committed registers; channel k occupies [k*REG_W +: REG_W].
- full  out  NUM_CH: channel holds REG_W/DIN_W nibbles since its last clear/commit.
- overflow  out  NUM_CH: sticky; a SHIFT was attempted while the channel was full.
- commit_pulse  out  NUM_CH: one-cycle pulse the cycle after a successful commit.
- err  out  1: one-cycle pulse for a rejected command.
- rd_data  out  DIN_W: top nibble of the selected channel's shift register.

## Operation
- Reset values: all shift registers, shadows, counters, full, overflow, commit_pulse, err and rd_data are 0.
- Per channel: shift register sr (REG_W), counter cnt (0..NIBS, where NIBS = REG_W/DIN_W), shadow, overflow.
- Commands act only on channel `sel`; other channels hold. A NOP changes nothing except that pulses return to 0.
- **SHIFT**
  - If cnt < NIBS: sr <= {sr[REG_W-DIN_W-1:0], din}, cnt <= cnt+1. The first nibble loaded ends at the MSB after NIBS shifts.
  - If cnt == NIBS: sr and cnt are unchanged and overflow <= 1.
- **CLEAR**: sr <= 0, cnt <= 0, overflow <= 0. The shadow is untouched.
- **COMMIT**
  - Accepted only when cnt == NIBS: shadow <= sr, cnt <= 0, overflow <= 0, commit_pulse[sel] <= 1 next cycle. sr keeps its value.
  - Rejected when cnt < NIBS: err <= 1 and no state changes.
- **Invalid select** (sel ≥ NUM_CH) with any non-NOP command: no state change, err <= 1.
- full[k] is combinational from the registered cnt: full[k] = (cnt_k == NIBS).
- rd_data <= sr[sel][REG_W-1 -: DIN_W], sampled from the pre-edge value, every cycle. If sel is invalid, rd_data <= 0.
- No arithmetic beyond the counter increment. The counter is $clog2(NIBS+1) bits and never wraps; it saturates at NIBS.

## Timing
- Every command takes effect at the rising edge on which it is sampled. Results are visible on outputs the following cycle.
- commit_pulse and err are high for exactly one cycle per qualifying command. Back-to-back commits on different channels give back-to-back pulses.
- shadow_out changes only on an accepted COMMIT, updating one cycle after the command. It is never partially updated.
- The NIBS-th SHIFT sets full the next cycle. A COMMIT issued in that next cycle is accepted, so the full sequence is NIBS+1 cycles minimum.
- rst has priority over cmd in the same cycle. Reset mid-load discards all partial and committed data.
- The command interface has no backpressure. The host observes full and overflow to pace itself.

## Structure
- Package `nibble_loader_pkg`:
  - cmd_e enum: CMD_NOP, CMD_SHIFT, CMD_CLEAR, CMD_COMMIT.
  - The NIBS and counter-width derivations as functions of REG_W and DIN_W.
- Sub-module `nibble_loader_channel`: one channel's sr, cnt, shadow, overflow and commit_pulse, driven by a decoded per-channel command.
- The top level holds:
  - a generate loop instantiating the channels
  - sel decode and validity check
  - err generation
  - the rd_data mux register

## Test plan
Parameters for all scenarios: NUM_CH=3, REG_W=32, DIN_W=4.
- **Load and commit**: SHIFT din=1..8 on ch0, then COMMIT ch0.
  - full[0]=1 after the 8th shift.
  - shadow ch0=0x12345678.
  - commit_pulse[0]=1 for one cycle.
  - full[0]=0 afterwards.
  - Other shadows stay 0.
- **Overflow**: 8 shifts of 0xA, then a 9th SHIFT din=0xF on ch1.
  - sr stays 0xAAAAAAAA.
  - overflow[1]=1, sticky until CLEAR ch1, which sets overflow=0 and full=0.
- **Early commit**: 5 shifts on ch2, then COMMIT.
  - err pulses once.
  - shadow ch2 stays 0.
  - 3 more shifts then COMMIT succeeds.
- **Invalid select**: sel=3 with SHIFT or COMMIT.
  - err=1 for one cycle.
  - No channel state changes.
  - rd_data=0.
- **Readback**: after loading 0x9ABCDEF0 into ch1 and holding sel=1, rd_data=0x9 one cycle later.
- **Reset mid-load**: rst asserted after 4 shifts, with a commit issued in the same cycle.
  - Every output is 0 next cycle.
  - The commit is ignored.
  - A fresh 8-nibble load then commits correctly.
